// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle between the execute stage, the load/store controller and the
// synchronous data ram. The controller uses the slave modport; the pipeline
// and ram side (or a bench standing in for them) use the master modport.
interface lsu_mem_ctrl_if;
  // pipeline request
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // pipeline response
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // data ram port
  logic        ramR;
  logic        ramW;
  logic [31:0] ramAddr;
  logic [31:0] ramDataW;
  logic [31:0] ramDataR;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, ramDataR,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ramR, ramW, ramAddr, ramDataW
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, ramDataR,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ramR, ramW, ramAddr, ramDataW
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the execute stage and a synchronous data ram
// without byte enables. One request is in flight at a time. Sub-word stores
// are done as read-modify-write; loads return sign/zero-extended lane data.
// Errors (illegal funct3, misalignment, out-of-window address) are answered
// in one cycle without touching the ram.
module lsu_mem_ctrl #(
  parameter int unsigned BASE_WORD   = 64,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input logic           clock,
  input logic           nReset,
  lsu_mem_ctrl_if.slave bus
);

  // Inclusive word-index window of the ram.
  localparam logic [29:0] WORD_LO = 30'(BASE_WORD);
  localparam logic [29:0] WORD_HI = 30'(BASE_WORD + DEPTH_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t      state_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  offset_r;
  logic [31:0] wdata_r;
  logic [31:0] ram_addr_r;
  logic [31:0] ram_wdata_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;

  logic        req_err_s;
  logic        req_is_sw_s;

  // Returns 1 when the request cannot be executed: illegal funct3 for its
  // direction, misaligned half/word, or word index outside the ram window.
  function automatic logic req_error(input logic        we,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr);
    logic legal;
    logic misaligned;
    logic out_of_range;
    case (f3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~we;
      default:                legal = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    out_of_range = (addr[31:2] < WORD_LO) || (addr[31:2] > WORD_HI);
    return ~legal | misaligned | out_of_range;
  endfunction

  // Picks the addressed lane out of a little-endian word and extends it.
  // f3[2] selects zero extension (LBU/LHU); LW passes the word through.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] result;
    case (off)
      2'b00:   lane_b = word[7:0];
      2'b01:   lane_b = word[15:8];
      2'b10:   lane_b = word[23:16];
      2'b11:   lane_b = word[31:24];
      default: lane_b = 8'h00;
    endcase
    if (off[1]) begin
      lane_h = word[31:16];
    end else begin
      lane_h = word[15:0];
    end
    case (f3)
      3'b000:  result = {{24{lane_b[7]}}, lane_b};
      3'b001:  result = {{16{lane_h[15]}}, lane_h};
      3'b010:  result = word;
      3'b100:  result = {24'h000000, lane_b};
      3'b101:  result = {16'h0000, lane_h};
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

  // Replaces the addressed byte or half-word of the old ram word with the
  // low bits of the store data; the other lanes are kept.
  function automatic logic [31:0] store_merge(input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] old_word,
                                              input logic [31:0] wdata);
    logic [31:0] result;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   result = {old_word[31:8], wdata[7:0]};
          2'b01:   result = {old_word[31:16], wdata[7:0], old_word[7:0]};
          2'b10:   result = {old_word[31:24], wdata[7:0], old_word[15:0]};
          2'b11:   result = {wdata[7:0], old_word[23:0]};
          default: result = old_word;
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          result = {wdata[15:0], old_word[15:0]};
        end else begin
          result = {old_word[31:16], wdata[15:0]};
        end
      end
      default: result = wdata;
    endcase
    return result;
  endfunction

  assign req_err_s   = req_error(bus.req_we, bus.req_funct3, bus.req_addr);
  assign req_is_sw_s = bus.req_we & (bus.req_funct3 == 3'b010);

  // Request sequencer: accepts in IDLE, walks RD/CAP/WR as the access needs,
  // and updates the response registers only on the edge that enters RESP.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      offset_r     <= 2'b00;
      wdata_r      <= 32'h0000_0000;
      ram_addr_r   <= 32'h0000_0000;
      ram_wdata_r  <= 32'h0000_0000;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            we_r       <= bus.req_we;
            funct3_r   <= bus.req_funct3;
            offset_r   <= bus.req_addr[1:0];
            wdata_r    <= bus.req_wdata;
            ram_addr_r <= {2'b00, bus.req_addr[31:2]};
            if (req_err_s) begin
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
              state_r      <= RESP;
            end else if (req_is_sw_s) begin
              ram_wdata_r <= bus.req_wdata;
              state_r     <= WR;
            end else begin
              state_r <= RD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          state_r <= CAP;
        end
        CAP: begin
          if (we_r) begin
            ram_wdata_r <= store_merge(funct3_r[1:0], offset_r, bus.ramDataR, wdata_r);
            state_r     <= WR;
          end else begin
            resp_rdata_r <= load_extend(funct3_r, offset_r, bus.ramDataR);
            resp_err_r   <= 1'b0;
            state_r      <= RESP;
          end
        end
        WR: begin
          resp_rdata_r <= 32'h0000_0000;
          resp_err_r   <= 1'b0;
          state_r      <= RESP;
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Strobes decode from the state register alone, so ramR and ramW are
  // mutually exclusive and glitch-free with respect to the request inputs.
  assign bus.req_ready  = (state_r == IDLE);
  assign bus.resp_valid = (state_r == RESP);
  assign bus.ramR       = (state_r == RD);
  assign bus.ramW       = (state_r == WR);
  assign bus.ramAddr    = ram_addr_r;
  assign bus.ramDataW   = ram_wdata_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;

endmodule
